// File: rtl/padder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : padder_pkg
//  Description : Shared types and constants for the pad10*1 block padder.
//  Revision    : 1.0  initial release
// ============================================================================
package padder_pkg;

    // Padder control states
    typedef enum logic [1:0] {
        ACCEPT = 2'd0,   // taking message words from the source
        PAD    = 2'd1,   // filling the rest of the block with zero words
        FULL   = 2'd2    // block presented, waiting for the permutation ack
    } state_t;

    localparam logic [7:0] KECCAK_DOMAIN = 8'h01;
    localparam logic [7:0] SHA3_DOMAIN   = 8'h06;
    localparam logic [7:0] PAD_END       = 8'h80;

    // Counter width that stays legal (>= 1 bit) for degenerate sizes
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/padder_word.sv
`default_nettype none
// ============================================================================
//  Module      : padder_word
//  Description : Builds the final message word: byte_num data bytes (MSB
//                first), then the domain byte, then zero bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module padder_word
    import padder_pkg::*;
#(
    parameter int          IN_W   = 32,
    parameter logic [7:0]  DOMAIN = KECCAK_DOMAIN
)(
    input  logic [IN_W-1:0]                   i_word,
    input  logic [clog2_min1(IN_W/8)-1:0]     i_byte_num,
    output logic [IN_W-1:0]                   o_word
);

    localparam int NB = IN_W / 8;

    // Byte 0 is the most significant byte; keep bytes below byte_num,
    // place the domain byte at byte_num, zero the rest.
    always_comb begin
        o_word = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(i_byte_num)) begin
                o_word[IN_W-1-8*j -: 8] = i_word[IN_W-1-8*j -: 8];
            end else if (j == int'(i_byte_num)) begin
                o_word[IN_W-1-8*j -: 8] = DOMAIN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/padder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : padder_pipe
//  Description : Collects IN_W-bit message words into RATE-bit blocks,
//                applies pad10*1 with a domain byte and hands complete
//                blocks to the permutation under a valid/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module padder_pipe
    import padder_pkg::*;
#(
    parameter int          IN_W   = 32,
    parameter int          RATE   = 576,
    parameter logic [7:0]  DOMAIN = KECCAK_DOMAIN
)(
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [IN_W-1:0]                   in,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic [clog2_min1(IN_W/8)-1:0]     byte_num,
    output logic                              buffer_full,
    output logic [RATE-1:0]                   out,
    output logic                              out_valid,
    output logic                              out_last,
    input  logic                              f_ack
);

    localparam int               WORDS    = RATE / IN_W;
    localparam int               CNT_W    = clog2_min1(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [RATE-1:0]    r_block;
    logic               r_out_valid;
    logic               r_out_last;

    logic [IN_W-1:0]    w_last_word;
    logic [IN_W-1:0]    w_wr_data;
    logic [RATE-1:0]    w_block_nxt;
    logic               w_wr;
    logic               w_slot_last;
    logic               w_blk_done;
    logic               w_msg_done;
    logic               w_ack;

    padder_word #(
        .IN_W   (IN_W),
        .DOMAIN (DOMAIN)
    ) u_word (
        .i_word     (in),
        .i_byte_num (byte_num),
        .o_word     (w_last_word)
    );

    assign w_slot_last = (r_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle write/complete decisions
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_data   = '0;
        w_blk_done  = 1'b0;
        w_msg_done  = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ACCEPT: begin
                if (in_valid) begin
                    w_wr = 1'b1;
                    if (in_last) begin
                        w_wr_data = w_last_word;
                        if (w_slot_last) begin
                            w_blk_done  = 1'b1;
                            w_msg_done  = 1'b1;
                            w_state_nxt = FULL;
                        end else begin
                            w_state_nxt = PAD;
                        end
                    end else begin
                        w_wr_data = in;
                        if (w_slot_last) begin
                            w_blk_done  = 1'b1;
                            w_state_nxt = FULL;
                        end
                    end
                end
            end
            PAD: begin
                w_wr = 1'b1;
                if (w_slot_last) begin
                    w_blk_done  = 1'b1;
                    w_msg_done  = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (f_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ACCEPT;
                end
            end
            default: begin
                w_state_nxt = ACCEPT;
            end
        endcase
        // The closing 1 of pad10*1 always lands in the block's last byte,
        // which may be the same byte as the domain byte.
        if (w_msg_done) begin
            w_wr_data = w_wr_data | IN_W'(PAD_END);
        end
    end

    // Merge the word being written into slot r_cnt (slot 0 in the MSBs)
    always_comb begin
        w_block_nxt = r_block;
        for (int k = 0; k < WORDS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_block_nxt[RATE-1-k*IN_W -: IN_W] = w_wr_data;
            end
        end
    end

    // Block storage, slot counter and handshake flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_block <= w_block_nxt;
                r_cnt   <= w_slot_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_blk_done) begin
                r_out_valid <= 1'b1;
            end
            if (w_msg_done) begin
                r_out_last <= 1'b1;
            end
            if (w_ack) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_cnt       <= '0;
            end
        end
    end

    assign out         = r_block;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign buffer_full = (r_state != ACCEPT);

endmodule
`default_nettype wire

// File: doc/padder_pipe.md
Name: padder_pipe

Overview:
- Parametrised successor to the single-word pad function in the Keccak/SHA-3 low-throughput core.
- Collects IN_W-bit message words into a RATE-bit block and applies multi-rate padding (pad10*1) with a configurable domain byte (Keccak 0x01 or SHA-3 0x06).
- Presents complete blocks to the f_permutation stage under a valid/ack handshake.
- Returns to accepting a new message after the final block is acknowledged.

Parameters:
- IN_W, 32, input word width in bits; multiple of 8, divides RATE.
- RATE, 576, block width in bits (576/832/1088/1152).
- DOMAIN, 8'h01, domain separation byte placed after the last message byte.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  IN_W  message word; first byte in in[IN_W-1:IN_W-8].
- in_valid  in  1  word present this cycle.
- in_last  in  1  with in_valid: final word, holding byte_num valid bytes.
- byte_num  in  $clog2(IN_W/8)  valid byte count of the final word, 0..IN_W/8-1.
- buffer_full  out  1  high: no input accepted this cycle.
- out  out  RATE  block; word 0 in the MSBs, last block byte in out[7:0].
- out_valid  out  1  block complete and stable.
- out_last  out  1  with out_valid: final block of the message.
- f_ack  in  1  permutation has consumed the block.

Behaviour:
- Reset (async assert, sync release):
  - out=0, out_valid=0, out_last=0, buffer_full=0.
  - Word counter cnt=0, state ACCEPT.
- WORDS = RATE/IN_W; cnt is $clog2(WORDS) bits and wraps to 0 when a block completes.
- ACCEPT:
  - in_valid && !in_last: shift the word into the block at index cnt; cnt++.
  - cnt reaching WORDS: out_valid=1, buffer_full=1, go to FULL (out_last=0).
- in_valid && in_last (in ACCEPT):
  - Store the padder_word result: byte_num data bytes, then DOMAIN, then zeros.
  - If that slot is word WORDS-1: OR 8'h80 into out[7:0], set out_last, go to FULL.
  - Otherwise go to PAD.
- PAD:
  - One all-zero word per cycle; buffer_full=1.
  - The word at index WORDS-1 gets 8'h80 in its last byte; then out_valid=1, out_last=1, go to FULL.
- Same-byte case: last slot with byte_num=IN_W/8-1 gives last byte DOMAIN|8'h80 (8'h81 / 8'h86).
- A full-length final word is sent as a non-last word, followed by in_last with byte_num=0. That last word is {DOMAIN, zeros}.
- The last-word slot is index cnt, so in_last in the block's first slot (cnt=0) yields a wholly padded block.
- FULL:
  - out and out_valid are held until f_ack.
  - On f_ack: out_valid=0 and cnt=0 next cycle.
  - Next state is ACCEPT if !out_last, else ACCEPT with out_last cleared (new message).
  - buffer_full is deasserted the cycle after f_ack.
- Backpressure: buffer_full = (state != ACCEPT). in_valid while buffer_full is ignored; the source holds the word.
- f_ack outside FULL: ignored.
- Latency: the block's final word (or pad word) arrives at cycle t; out_valid rises at t+1.
- Reset mid-block: discards partial contents immediately; no block is emitted.

Decomposition:
- Package padder_pkg: state enum {ACCEPT, PAD, FULL}; KECCAK_DOMAIN=8'h01, SHA3_DOMAIN=8'h06, PAD_END=8'h80.
- Sub-module padder_word (combinational, IN_W/DOMAIN params): {in, byte_num} -> word with DOMAIN inserted at byte byte_num and zeros after it.

Test Plan:
- IN_W=32, RATE=576, DOMAIN=06: 18 non-last words 0x00000001..0x00000012, then in_last byte_num=0 -> block 1 out_valid, out_last=0. After f_ack, block 2 = 0x06000000, zeros, out[7:0]=0x80, out_last=1.
- in_last at cnt=3, in=0x11223344, byte_num=2 -> word3=0x11220600; PAD 14 cycles with buffer_full=1; out[7:0]=0x80; out_valid 15 cycles after in_last.
- in_last at cnt=17, byte_num=3, in=0xAABBCCDD -> out[31:0]=0xAABBCC86, out_last=1, no PAD cycles.
- out_valid held with f_ack low for 10 cycles, in_valid toggling -> out stable, cnt unchanged, no word absorbed. f_ack pulse -> buffer_full low next cycle.
- reset_n low at cnt=9 -> outputs zero asynchronously. Resending a fresh 18-word block yields exactly those words.
- DOMAIN=01, in_last at cnt=0, byte_num=0 -> block = 0x01 first byte, 0x80 last byte, out_last=1.
